// File: rtl/freertos_key_event_ctrl_pkg.sv
// rtl/freertos_key_event_ctrl_pkg.sv - register map, status bits and event-word layout shared by the key event block
package key_event_pkg;

  localparam logic [1:0] KEY_ADDR_STATE  = 2'd0;
  localparam logic [1:0] KEY_ADDR_EVENT  = 2'd1;
  localparam logic [1:0] KEY_ADDR_MASK   = 2'd2;
  localparam logic [1:0] KEY_ADDR_STATUS = 2'd3;

  localparam int EVT_VALID   = 31;
  localparam int EVT_KEY_LSB = 8;
  localparam int EVT_KEY_W   = 3;
  localparam int EVT_DIR     = 0;

  localparam int STS_COUNT_W = 7;
  localparam int STS_OVF     = 16;
  localparam int STS_FLUSH   = 17;
  localparam int STS_PEND    = 17;

  typedef struct packed {
    logic [EVT_KEY_W-1:0] key;
    logic                 dir;
  } key_evt_t;

  function automatic logic [31:0] evt_word(input key_evt_t e);
    logic [31:0] w;
    w                            = '0;
    w[EVT_VALID]                 = 1'b1;
    w[EVT_KEY_LSB +: EVT_KEY_W]  = e.key;
    w[EVT_DIR]                   = e.dir;
    return w;
  endfunction

endpackage

// File: rtl/freertos_key_event_ctrl_debounce.sv
// rtl/freertos_key_event_ctrl_debounce.sv - per-key synchronizer, debounce counter and change pulse
// Counter present only with KEY_EVENT_DEBOUNCE_EN; otherwise stable follows the synchronized pin.
module key_debounce
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin_n,
  output logic o_stable,
  output logic o_change
);

  logic r_sync1;
  logic r_sync2;
  logic r_stable;
  logic r_change;
  logic w_sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pin_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = ~r_sync2;

`ifdef KEY_EVENT_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // any cycle agreeing with the accepted level restarts the stability window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_change <= 1'b0;
    end else if (w_sample == r_stable) begin
      r_cnt    <= '0;
      r_change <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_sample;
      r_change <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_change <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_stable <= w_sample;
      r_change <= w_sample ^ r_stable;
    end
  end
`endif

  assign o_stable = r_stable;
  assign o_change = r_change;

endmodule

// File: rtl/freertos_key_event_ctrl.sv
// rtl/freertos_key_event_ctrl.sv - debounced key press/release event FIFO with Avalon-MM registers and irq
// Optional debounce counters: KEY_EVENT_DEBOUNCE_EN.
module freertos_key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] in_port,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_change;

  for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_pin_n  (in_port[gk]),
      .o_stable (w_stable[gk]),
      .o_change (w_change[gk])
    );
  end

  logic [NUM_KEYS-1:0] r_pend;
  logic [NUM_KEYS-1:0] r_dir;
  logic                r_ovf;
  logic [1:0]          r_mask;
  logic                r_irq;
  logic [31:0]         r_readdata;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  key_evt_t            r_mem [FIFO_DEPTH];

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_wr_status;
  logic                w_flush;
  logic                w_ovf_clr;
  logic                w_ovf_set;
  logic [NUM_KEYS-1:0] w_grant;
  logic [NUM_KEYS-1:0] w_pend_clr;
  key_evt_t            w_grant_evt;
  logic [31:0]         w_status;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = read && (address == KEY_ADDR_EVENT) && !w_empty;
  assign w_wr_status = write && (address == KEY_ADDR_STATUS);
  assign w_flush     = w_wr_status && writedata[STS_FLUSH];
  assign w_ovf_clr   = w_wr_status && writedata[STS_OVF];

  // lowest-index pending key wins; scanning downward leaves the lowest one last
  always_comb begin
    w_grant     = '0;
    w_grant_evt = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_grant         = '0;
        w_grant[k]      = 1'b1;
        w_grant_evt.key = EVT_KEY_W'(k);
        w_grant_evt.dir = r_dir[k];
      end
    end
  end

  // a pop frees the slot the grant needs in the same cycle; a flush discards the push
  assign w_push     = (|r_pend) && (!w_full || w_pop) && !w_flush;
  assign w_pend_clr = w_push ? w_grant : '0;
  assign w_ovf_set  = |(w_change & r_pend & ~w_pend_clr);

  always_comb begin
    w_status                        = '0;
    w_status[STS_COUNT_W-1:0]       = STS_COUNT_W'(r_count);
    w_status[STS_OVF]               = r_ovf;
    w_status[STS_PEND]              = |r_pend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_dir  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_flush ? w_change : ((r_pend & ~w_pend_clr) | w_change);
      r_dir  <= (r_dir & ~w_change) | (w_stable & w_change);
      r_ovf  <= w_ovf_set | (r_ovf & ~w_ovf_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (write && (address == KEY_ADDR_MASK)) begin
        r_mask <= writedata[1:0];
      end
      r_irq <= (!w_empty && r_mask[0]) || (r_ovf && r_mask[1]);
      if (read) begin
        case (address)
          KEY_ADDR_STATE:  r_readdata <= 32'(w_stable);
          KEY_ADDR_EVENT:  r_readdata <= w_pop ? evt_word(r_mem[r_rd_ptr]) : '0;
          KEY_ADDR_MASK:   r_readdata <= {30'd0, r_mask};
          default:         r_readdata <= w_status;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_freertos_key_event_ctrl.sv
// tb/tb_freertos_key_event_ctrl.sv - scoreboard bench for freertos_key_event_ctrl (either KEY_EVENT_DEBOUNCE_EN build)
module tb_freertos_key_event_ctrl;

  localparam int NK = 4;
  localparam int DC = 200;
  localparam int FD = 8;
`ifdef KEY_EVENT_DEBOUNCE_EN
  localparam int DCEFF = DC;
`else
  localparam int DCEFF = 1;
`endif
  localparam int SETTLE = DCEFF + 8;

  localparam logic [1:0] A_STATE  = 2'd0;
  localparam logic [1:0] A_EVENT  = 2'd1;
  localparam logic [1:0] A_MASK   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic          clk;
  logic          reset_n;
  logic [NK-1:0] in_port;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  freertos_key_event_ctrl #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DC),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;
  logic rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // read monitor: a read sampled at a posedge is answered on readdata by the next negedge
  always @(posedge clk) rd_seen <= read;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, readdata, mon_e.val);
      end
    end
  end

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.val  = exp;
    @(negedge clk);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_port   = '1;
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    bus_read(A_STATUS, 32'h0, "rst_status");
    bus_read(A_MASK,   32'h0, "rst_mask");
    bus_read(A_EVENT,  32'h0, "rst_event_empty");

    // key 2 clean press with event irq enabled; irq rises DCEFF+5 edges after the pin change
    bus_write(A_MASK, 32'h1);
    in_port = 4'b1011;
    repeat (DCEFF + 4) @(posedge clk);
    #1 check("irq_not_yet", 32'(irq), 32'h0);
    @(posedge clk);
    #1 check("irq_after_push", 32'(irq), 32'h1);
    bus_read(A_STATE,  32'h4, "state_key2");
    bus_read(A_STATUS, 32'h1, "status_count1");
    bus_read(A_EVENT,  32'h8000_0201, "event_key2_press");
    @(posedge clk);
    #1 check("irq_drop", 32'(irq), 32'h0);
    bus_read(A_STATUS, 32'h0, "status_count0");
    in_port = 4'hF;
    settle();
    bus_read(A_EVENT,  32'h8000_0200, "event_key2_release");

`ifdef KEY_EVENT_DEBOUNCE_EN
    for (int i = 0; i < 100; i++) begin
      in_port[0] = i[0];
      repeat (100) @(negedge clk);
    end
`endif
    in_port = 4'b1110;
    settle();
    bus_read(A_STATUS, 32'h1, "bounce_one_event");
    bus_read(A_EVENT,  32'h8000_0001, "event_key0_press");
    bus_read(A_STATE,  32'h1, "state_key0");
    bus_read(A_EVENT,  32'h0, "bounce_no_second");
    in_port = 4'hF;
    settle();
    bus_read(A_EVENT,  32'h8000_0000, "event_key0_release");

    // keys 1 and 3 change in the same cycle: lower index queued first
    in_port = 4'b0101;
    settle();
    bus_read(A_STATE,  32'hA, "state_k1_k3");
    bus_read(A_EVENT,  32'h8000_0101, "event_k1_press");
    bus_read(A_EVENT,  32'h8000_0301, "event_k3_press");
    in_port = 4'hF;
    settle();
    bus_read(A_STATUS, 32'h2, "status_two_releases");
    bus_read(A_EVENT,  32'h8000_0100, "event_k1_release");
    bus_read(A_EVENT,  32'h8000_0300, "event_k3_release");

    // overflow: eight events fill the FIFO, 9th held pending, 10th overwrites it
    bus_write(A_MASK, 32'h2);
    for (int i = 0; i < 4; i++) begin
      in_port = 4'b1110;
      settle();
      in_port = 4'hF;
      settle();
    end
    bus_read(A_STATUS, 32'h0000_0008, "status_full");
    in_port = 4'b1110;
    settle();
    check("irq_full_no_ovf", 32'(irq), 32'h0);
    bus_read(A_STATUS, 32'h0002_0008, "status_9th_pending");
    in_port = 4'hF;
    settle();
    check("irq_ovf", 32'(irq), 32'h1);
    bus_read(A_STATUS, 32'h0003_0008, "status_ovf");
    bus_write(A_STATUS, 32'h0001_0000);
    @(posedge clk);
    #1 check("irq_ovf_cleared", 32'(irq), 32'h0);
    bus_read(A_STATUS, 32'h0002_0008, "status_ovf_w1c");

    // pop while full lets the pending grant in; then flush with a fresh pending key
    bus_read(A_EVENT,  32'h8000_0001, "event_pop_full");
    bus_read(A_STATUS, 32'h0000_0008, "status_pop_push");
    in_port = 4'b1110;
    settle();
    bus_read(A_STATUS, 32'h0002_0008, "status_pend_before_flush");
    bus_write(A_STATUS, 32'h0002_0000);
    bus_read(A_STATUS, 32'h0, "status_flushed");
    bus_read(A_EVENT,  32'h0, "event_after_flush");
    in_port = 4'hF;
    settle();
    bus_read(A_EVENT,  32'h8000_0000, "event_post_flush");

    // reset in the middle of traffic
    bus_write(A_MASK, 32'h1);
    in_port = 4'b1101;
    settle();
    check("irq_pre_reset", 32'(irq), 32'h1);
    bus_read(A_STATE, 32'h2, "state_pre_reset");
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_STATUS, 32'h0, "midrst_status");
    bus_read(A_MASK,   32'h0, "midrst_mask");
    bus_read(A_EVENT,  32'h0, "midrst_event");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL read_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
